debounce_multi: RTL and testbench

- Parametrised multi-channel switch/button debouncer; successor to the single-channel chatter filter used on board switches.
- Each channel has:
  - a metastability synchroniser;
  - optional per-channel input inversion;
  - a configurable tick period and stable-tick threshold;
  - one-cycle rise/fall event pulses, so downstream logic (capture trigger, mode select) needs no edge detector.
- One prescaler is shared by all channels; one instance replaces N single-channel debouncers.

---
 rtl/debounce_multi_pkg.sv | 31 +++
 rtl/debounce_multi_chan.sv | 99 +++++++++
 rtl/debounce_multi.sv | 76 +++++++
 tb/tb_debounce_multi.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_multi_pkg.sv
// -----------------------------------------------------------------------------
// debounce_multi_pkg
//   Shared defaults and helpers for the multi-channel switch debouncer.
//   DEF_TICK_DIV gives a ~10.5 ms sample tick from a 50 MHz clk. With three
//   stable ticks, a level must hold for roughly 21..31 ms before db follows it.
// -----------------------------------------------------------------------------
package debounce_multi_pkg;

    localparam int DEF_CH           = 4;
    localparam int DEF_TICK_DIV     = 524288;
    localparam int DEF_STABLE_TICKS = 3;
    localparam int DEF_SYNC_STAGES  = 2;

    // Bits needed to hold values 0..value-1. The result is never below 1,
    // so degenerate parameter choices still give a legal vector width.
    function automatic int clog2(input longint unsigned value);
        int              width;
        longint unsigned span;
        width = 0;
        span  = 1;
        while (span < value) begin
            span  = span << 1;
            width = width + 1;
        end
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/debounce_multi_chan.sv
// -----------------------------------------------------------------------------
// debounce_multi_chan
//   One debounce channel. It contains:
//     - a synchroniser;
//     - optional inversion of the input;
//     - a stable-tick counter;
//     - the debounced level and its rise/fall event pulses.
//
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   STABLE     | s == db, cnt == 0; no change pending
//   PENDING_k  | s != db, k sample ticks seen while disagreeing (cnt == k)
//
//   Agreement on any single cycle returns the channel to STABLE. db takes the
//   value of s on the STABLE_TICKS-th tick of disagreement. In that same cycle,
//   rise or fall is raised for one cycle.
//
// Ports
//   clk    in   system clock
//   reset  in   async, active-high
//   tick   in   shared prescaler tick (one cycle wide)
//   sw_in  in   raw asynchronous switch input
//   db     out  debounced, polarity-corrected level
//   rise   out  one-cycle pulse on db 0->1
//   fall   out  one-cycle pulse on db 1->0
// -----------------------------------------------------------------------------
module debounce_multi_chan
    import debounce_multi_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter bit INVERT       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sw_in,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int             CW       = clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   db_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;

    // Each synchroniser flop resets to INVERT. The post-inversion value is
    // then 0 and matches db, so no event fires after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{INVERT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

    always_comb begin
        cnt_nxt  = cnt;
        db_nxt   = db;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        if (s == db) begin
            cnt_nxt = '0;
        end else if (tick) begin
            if (cnt >= CNT_LAST) begin
                db_nxt   = s;
                cnt_nxt  = '0;
                rise_nxt = s;
                fall_nxt = ~s;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            db   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            db   <= db_nxt;
            rise <= rise_nxt;
            fall <= fall_nxt;
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//   Debouncer for CH independent switches. One prescaler drives the sample
//   tick for every channel. Each channel synchronises its input and can invert
//   it (ACTIVE_LOW). A channel flips db after STABLE_TICKS consecutive ticks of
//   disagreement, and marks the flip with one-cycle rise/fall pulses.
//
// Ports
//   clk    in   system clock
//   reset  in   async, active-high
//   sw_in  in   [CH] raw asynchronous switch inputs
//   db     out  [CH] debounced level, 1 = pressed
//   rise   out  [CH] one-cycle pulse on db 0->1
//   fall   out  [CH] one-cycle pulse on db 1->0
//   tick   out  prescaler tick, exposed for observation
// -----------------------------------------------------------------------------
module debounce_multi
    import debounce_multi_pkg::*;
#(
    parameter int            CH           = DEF_CH,
    parameter int            TICK_DIV     = DEF_TICK_DIV,
    parameter int            STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int            SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter logic [CH-1:0] ACTIVE_LOW   = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] sw_in,
    output logic [CH-1:0] db,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic          tick
);

    localparam int            PW         = clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic          tick_nxt;

    // tick is registered from the next count value. It is therefore high in
    // exactly the cycle where the count reads TICK_DIV-1. The prescaler runs
    // freely and is never restarted by input activity.
    always_comb begin
        presc_nxt = (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        tick_nxt  = (presc_nxt == PRESC_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            presc <= presc_nxt;
            tick  <= tick_nxt;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        debounce_multi_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .SYNC_STAGES  (SYNC_STAGES),
            .INVERT       (ACTIVE_LOW[i])
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .sw_in (sw_in[i]),
            .db    (db[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
//   Directed bench for debounce_multi with these parameters:
//     CH=4, TICK_DIV=8, STABLE_TICKS=3, SYNC_STAGES=2, ACTIVE_LOW=4'b1000.
//   Inputs are driven on the falling edge, and outputs are sampled there too.
//   Latencies are counted in falling edges after the edge that drives the input.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw_in;
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       tick;

    int checks   = 0;
    int failures = 0;
    int rise_cnt [4];
    int fall_cnt [4];

    logic [3:0] db_prev    = 4'b0000;
    logic       reset_prev = 1'b1;

    always #5 clk = ~clk;

    debounce_multi #(
        .CH           (4),
        .TICK_DIV     (8),
        .STABLE_TICKS (3),
        .SYNC_STAGES  (2),
        .ACTIVE_LOW   (4'b1000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw_in (sw_in),
        .db    (db),
        .rise  (rise),
        .fall  (fall),
        .tick  (tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every db change must carry the matching pulse, and no pulse may appear
    // without a change. Cycles inside or right after reset are skipped,
    // because reset clears db without emitting an event.
    always @(negedge clk) begin
        if (!reset && !reset_prev) begin
            for (int i = 0; i < 4; i++) begin
                if (db[i] != db_prev[i]) begin
                    check("evt_rise", rise[i], db[i]);
                    check("evt_fall", fall[i], !db[i]);
                end else if (rise[i] || fall[i]) begin
                    check("pulse_without_flip", {rise[i], fall[i]}, 0);
                end
                if (rise[i]) rise_cnt[i]++;
                if (fall[i]) fall_cnt[i]++;
            end
        end
        db_prev    <= db;
        reset_prev <= reset;
    end

    // Waits for the next tick, then k more falling edges. After k=6, an input
    // driven now becomes s just before the next tick is consumed. The first
    // flip then lands 19 edges after the drive: 2 sync + 1 + 2*8.
    task automatic align_tick(input int k);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (tick !== 1'b1 && guard < 20);
        check("tick_seen", tick, 1);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_db(input int ch, input logic val, input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (db[ch] !== val && n < max_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        int         nticks;
        int         fall_at;
        logic [3:0] acc_db;
        logic [3:0] acc_evt;
        logic       acc1;

        // Reset state: the active-low channel is held released (pin high).
        reset = 1'b1;
        sw_in = 4'b1000;
        repeat (3) @(negedge clk);
        check("rst_db",   db,   0);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        check("rst_tick", tick, 0);
        reset = 1'b0;

        // 100 idle cycles: no level change and no events. Any 96-cycle
        // window holds exactly 12 ticks.
        acc_db  = '0;
        acc_evt = '0;
        nticks  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acc_db  |= db;
            acc_evt |= rise | fall;
            if (i < 96 && tick) nticks++;
        end
        check("idle_db",    acc_db,  0);
        check("idle_evt",   acc_evt, 0);
        check("idle_ticks", nticks,  12);

        // Press on channel 0.
        align_tick(6);
        sw_in[0] = 1'b1;
        wait_db(0, 1'b1, 40, n);
        check("press0_db",   db[0],   1);
        check("press0_lat",  n,       19);
        check("press0_rise", rise[0], 1);
        @(negedge clk);
        check("press0_rise_width", rise[0],     0);
        check("press0_rise_count", rise_cnt[0], 1);

        // Chatter on channel 1: it toggles every 5 cycles for 200 cycles, so no
        // disagreement run ever spans more than one tick.
        acc1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            sw_in[1] = (k % 2 == 0);
            repeat (5) begin
                @(negedge clk);
                acc1 |= db[1];
            end
        end
        repeat (10) @(negedge clk);
        check("chatter_db",   acc1,        0);
        check("chatter_rise", rise_cnt[1], 0);
        align_tick(6);
        sw_in[1] = 1'b1;
        wait_db(1, 1'b1, 40, n);
        check("hold1_db",  db[1], 1);
        check("hold1_lat", n,     19);

        // Release on channel 0 with a one-cycle glitch at edge 12. At that
        // point the count is 2. The glitch resets it, so qualification restarts
        // and the fall lands at 35, 23 edges after the glitch.
        align_tick(6);
        sw_in[0] = 1'b0;
        n        = 0;
        fall_at  = 0;
        while (n < 50 && fall_at == 0) begin
            @(negedge clk);
            n++;
            if (n == 12) sw_in[0] = 1'b1;
            if (n == 13) sw_in[0] = 1'b0;
            if (db[0] == 1'b0) fall_at = n;
        end
        check("glitch_fall_lat",  fall_at, 35);
        check("glitch_fall_puls", fall[0], 1);
        @(negedge clk);
        check("glitch_fall_count", fall_cnt[0], 1);

        // Simultaneous events: press on channel 3 (active-low, pin goes 0)
        // and press on channel 2 in the same cycle.
        align_tick(6);
        sw_in[3] = 1'b0;
        sw_in[2] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (db[3:2] == 2'b00 && n < 40);
        check("simul_db",   db[3:2],   2'b11);
        check("simul_lat",  n,         19);
        check("simul_rise", rise[3:2], 2'b11);
        @(negedge clk);
        check("simul_rise_count2", rise_cnt[2], 1);
        check("simul_rise_count3", rise_cnt[3], 1);

        // Reset pulsed while channel 0 has count 2. After release the
        // prescaler restarts at 0. Ticks are consumed at edges 8, 16 and 24,
        // so every pressed channel requalifies together at edge 24.
        align_tick(6);
        sw_in[0] = 1'b1;
        repeat (13) @(negedge clk);
        check("pend_db0", db[0], 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_db", db, 0);
        reset = 1'b0;
        wait_db(0, 1'b1, 40, n);
        check("requal_lat",  n,    24);
        check("requal_db",   db,   4'b1111);
        check("requal_rise", rise, 4'b1111);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
